edge_event_counter: RTL and testbench

Multi-channel, parametrised edge-event counter, the next-generation replacement for our single-channel rising-edge counter. Each channel counts qualifying edges on a level input: rising, falling or both, selectable per channel. Counting can wrap or saturate, with a sticky overflow flag. A coherent snapshot of all channels is taken on request. It sits between the radio/UART status lines and the register/readout logic; inputs may be asynchronous when synchroniser stages are enabled.

---
 rtl/edge_cnt_pkg.sv | 19 +
 rtl/edge_cnt_channel.sv | 93 +++++++++
 rtl/edge_event_counter.sv | 56 +++++
 tb/tb_edge_event_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_cnt_pkg.sv
// Shared definitions for the multi-channel edge-event counter:
// edge-select encodings and the packed-slice indexing helper.
package edge_cnt_pkg;

   localparam logic [1:0] EDGE_OFF  = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   // Bit positions within a channel's 2-bit mode field.
   localparam int MODE_RISE_BIT = 0;
   localparam int MODE_FALL_BIT = 1;

   // Base bit index of channel idx within a packed WIDTH*CHANNELS bus.
   function automatic int slice_base(input int width, input int idx);
      return width * idx;
   endfunction

endpackage

// File: rtl/edge_cnt_channel.sv
// One counter channel: optional input synchroniser, history register,
// edge qualification, wrap/saturate counter and sticky overflow.
module edge_cnt_channel
   import edge_cnt_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 0,
   parameter int SATURATE    = 0
) (
   input  logic             clk,
   input  logic             kill,
   input  logic             enb,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf
);

   logic             cur;
   logic             prev;
   logic             rise;
   logic             fall;
   logic             qualify;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_nxt;
   logic             ovf_q;
   logic             ovf_nxt;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign cur = enb;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync;

         always_ff @(posedge clk) begin
            if (kill) begin
               sync <= '0;
            end else begin
               for (int s = SYNC_STAGES - 1; s > 0; s--) begin
                  sync[s] <= sync[s-1];
               end
               sync[0] <= enb;
            end
         end

         assign cur = sync[SYNC_STAGES-1];
      end
   endgenerate

   // History tracks the input unconditionally so a mode change on a static
   // level can never manufacture an edge.
   always_ff @(posedge clk) begin
      if (kill) begin
         prev <= 1'b0;
      end else begin
         prev <= cur;
      end
   end

   assign rise    = cur & ~prev;
   assign fall    = ~cur & prev;
   assign qualify = (mode[MODE_RISE_BIT] & rise) | (mode[MODE_FALL_BIT] & fall);

   always_comb begin
      cnt_nxt = cnt_q;
      ovf_nxt = ovf_q;
      if (clr) begin
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (qualify) begin
         if (&cnt_q) begin
            ovf_nxt = 1'b1;
            cnt_nxt = (SATURATE != 0) ? cnt_q : '0;
         end else begin
            cnt_nxt = cnt_q + WIDTH'(1'b1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (kill) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         ovf_q <= ovf_nxt;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/edge_event_counter.sv
// Multi-channel edge-event counter: CHANNELS independent counters plus a
// shared snapshot bank loaded coherently from the live counts.
module edge_event_counter
   import edge_cnt_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 0,
   parameter int SATURATE    = 0
) (
   input  logic                      clk,
   input  logic                      kill,
   input  logic [CHANNELS-1:0]       enb,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS-1:0]       clr,
   input  logic                      snap,
   output logic [WIDTH*CHANNELS-1:0] cnt,
   output logic [WIDTH*CHANNELS-1:0] snap_cnt,
   output logic [CHANNELS-1:0]       ovf
);

   logic [WIDTH*CHANNELS-1:0] snap_q;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         localparam int BASE = slice_base(WIDTH, i);

         edge_cnt_channel #(
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_STAGES),
            .SATURATE   (SATURATE)
         ) u_channel (
            .clk (clk),
            .kill(kill),
            .enb (enb[i]),
            .mode(mode[2*i +: 2]),
            .clr (clr[i]),
            .cnt (cnt[BASE +: WIDTH]),
            .ovf (ovf[i])
         );
      end
   endgenerate

   // Loads from the registered counts, so a same-cycle edge or clear is not
   // reflected in the snapshot.
   always_ff @(posedge clk) begin
      if (kill) begin
         snap_q <= '0;
      end else if (snap) begin
         snap_q <= cnt;
      end
   end

   assign snap_cnt = snap_q;

endmodule

// File: tb/tb_edge_event_counter.sv
// Scoreboard bench for edge_event_counter: three DUT builds share stimulus
// (wrap, saturate, two-stage sync); expectations are queued with due cycles.
module tb_edge_event_counter;
   import edge_cnt_pkg::*;

   localparam int W  = 4;
   localparam int CH = 4;
   localparam int K_CNT  = 0;
   localparam int K_SNAP = 1;
   localparam int K_OVF  = 2;

   typedef struct {
      int    due;
      int    d;
      int    kind;
      int    ch;
      int    val;
      string name;
   } item_t;

   logic            clk = 1'b0;
   logic            kill;
   logic [CH-1:0]   enb;
   logic [2*CH-1:0] mode;
   logic [CH-1:0]   clr;
   logic            snap;

   logic [W*CH-1:0] cnt_o  [3];
   logic [W*CH-1:0] snap_o [3];
   logic [CH-1:0]   ovf_o  [3];

   item_t sb[$];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   edge_event_counter #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(0), .SATURATE(0)) dut_wrap (
      .clk(clk), .kill(kill), .enb(enb), .mode(mode), .clr(clr), .snap(snap),
      .cnt(cnt_o[0]), .snap_cnt(snap_o[0]), .ovf(ovf_o[0]));

   edge_event_counter #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(0), .SATURATE(1)) dut_sat (
      .clk(clk), .kill(kill), .enb(enb), .mode(mode), .clr(clr), .snap(snap),
      .cnt(cnt_o[1]), .snap_cnt(snap_o[1]), .ovf(ovf_o[1]));

   edge_event_counter #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(2), .SATURATE(0)) dut_sync (
      .clk(clk), .kill(kill), .enb(enb), .mode(mode), .clr(clr), .snap(snap),
      .cnt(cnt_o[2]), .snap_cnt(snap_o[2]), .ovf(ovf_o[2]));

   function automatic int observe(input int d, input int kind, input int ch);
      case (kind)
         K_CNT:   return int'(cnt_o[d][W*ch +: W]);
         K_SNAP:  return int'(snap_o[d][W*ch +: W]);
         default: return int'(ovf_o[d][ch]);
      endcase
   endfunction

   task automatic expect_at(input int off, input int d, input int kind, input int ch,
                            input int val, input string name);
      item_t it;
      it.due  = cyc + off;
      it.d    = d;
      it.kind = kind;
      it.ch   = ch;
      it.val  = val;
      it.name = name;
      sb.push_back(it);
   endtask

   // Monitor: every outputs-stable point, retire the items due now.
   always @(negedge clk) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].due == cyc) begin
            int got;
            got = observe(sb[k].d, sb[k].kind, sb[k].ch);
            total++;
            if (got != sb[k].val) begin
               bad++;
               $display("FAIL %s (dut%0d ch%0d): got %0d want %0d",
                        sb[k].name, sb[k].d, sb[k].ch, got, sb[k].val);
            end
            sb.delete(k);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch);
      enb[ch] = 1'b1;
      tick();
      enb[ch] = 1'b0;
      tick();
   endtask

   task automatic toggle6();
      for (int t = 0; t < 6; t++) begin
         enb[1] = ~enb[1];
         tick();
      end
   endtask

   task automatic clear_ch(input int ch);
      clr[ch] = 1'b1;
      tick();
      clr[ch] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      kill = 1'b1;
      enb  = 4'b0001;
      mode = '0;
      mode[0 +: 2] = EDGE_RISE;
      clr  = '0;
      snap = 1'b0;
      repeat (3) tick();

      for (int c = 0; c < CH; c++) begin
         expect_at(0, 0, K_CNT,  c, 0, "reset_cnt");
         expect_at(0, 0, K_SNAP, c, 0, "reset_snap");
         expect_at(0, 0, K_OVF,  c, 0, "reset_ovf");
      end

      // Input already high at reset release counts as one rising edge.
      kill = 1'b0;
      expect_at(1, 0, K_CNT, 0, 1, "release_edge");
      expect_at(1, 0, K_CNT, 1, 0, "release_other");
      expect_at(1, 0, K_OVF, 0, 0, "release_ovf");
      expect_at(1, 0, K_SNAP, 0, 0, "release_snap");
      expect_at(2, 2, K_CNT, 0, 0, "sync_not_yet");
      expect_at(3, 2, K_CNT, 0, 1, "sync_lands");
      repeat (4) tick();

      mode[2 +: 2] = EDGE_BOTH;
      toggle6();
      expect_at(0, 0, K_CNT, 1, 6, "both_edges");
      clear_ch(1);
      expect_at(0, 0, K_CNT, 1, 0, "clr_ch1");
      mode[2 +: 2] = EDGE_RISE;
      tick();
      expect_at(0, 0, K_CNT, 1, 0, "mode_change_static");
      toggle6();
      expect_at(0, 0, K_CNT, 1, 3, "rise_only");
      clear_ch(1);
      mode[2 +: 2] = EDGE_FALL;
      toggle6();
      expect_at(0, 0, K_CNT, 1, 3, "fall_only");

      mode[6 +: 2] = EDGE_RISE;
      for (int i = 0; i < 17; i++) begin
         enb[3] = 1'b1;
         tick();
         if (i == 14) begin
            expect_at(0, 0, K_CNT, 3, 15, "at_max");
            expect_at(0, 0, K_OVF, 3, 0,  "at_max_ovf");
         end
         if (i == 15) begin
            expect_at(0, 0, K_CNT, 3, 0,  "wrap_zero");
            expect_at(0, 0, K_OVF, 3, 1,  "wrap_ovf");
            expect_at(0, 1, K_CNT, 3, 15, "sat_hold");
         end
         enb[3] = 1'b0;
         tick();
      end
      expect_at(0, 0, K_CNT, 3, 1,  "wrap_17");
      expect_at(0, 0, K_OVF, 3, 1,  "wrap_17_ovf");
      expect_at(0, 1, K_CNT, 3, 15, "sat_17");
      expect_at(0, 1, K_OVF, 3, 1,  "sat_17_ovf");
      tick();
      expect_at(0, 0, K_OVF, 3, 1,  "ovf_sticky");
      clear_ch(3);
      expect_at(0, 0, K_CNT, 3, 0, "clr_wrap_cnt");
      expect_at(0, 0, K_OVF, 3, 0, "clr_wrap_ovf");
      expect_at(0, 1, K_CNT, 3, 0, "clr_sat_cnt");
      expect_at(0, 1, K_OVF, 3, 0, "clr_sat_ovf");

      // Clear wins over a simultaneous qualifying edge.
      mode[4 +: 2] = EDGE_RISE;
      repeat (5) pulse(2);
      expect_at(0, 0, K_CNT, 2, 5, "ch2_five");
      enb[2] = 1'b1;
      clr[2] = 1'b1;
      tick();
      clr[2] = 1'b0;
      expect_at(0, 0, K_CNT, 2, 0, "clr_beats_edge");
      repeat (3) tick();
      expect_at(0, 0, K_CNT, 2, 0, "held_high_no_count");

      clr[0] = 1'b1;
      enb[0] = 1'b0;
      tick();
      clr[0] = 1'b0;
      expect_at(0, 0, K_CNT, 0, 0, "clr_ch0");
      repeat (7) pulse(0);
      expect_at(0, 0, K_CNT, 0, 7, "ch0_seven");
      enb[0] = 1'b1;
      snap   = 1'b1;
      tick();
      snap   = 1'b0;
      expect_at(0, 0, K_SNAP, 0, 7, "snap_pre_inc");
      expect_at(0, 0, K_CNT,  0, 8, "cnt_post_inc");
      expect_at(0, 0, K_SNAP, 1, 3, "snap_ch1");
      expect_at(0, 0, K_SNAP, 3, 0, "snap_ch3");
      enb[0] = 1'b0;
      tick();
      enb[0] = 1'b1;
      tick();
      expect_at(0, 0, K_CNT,  0, 9, "count_after_snap");
      expect_at(0, 0, K_SNAP, 0, 7, "snap_holds");

      kill = 1'b1;
      tick();
      for (int c = 0; c < CH; c++) begin
         expect_at(0, 0, K_CNT,  c, 0, "kill_cnt");
         expect_at(0, 0, K_SNAP, c, 0, "kill_snap");
         expect_at(0, 0, K_OVF,  c, 0, "kill_ovf");
      end
      expect_at(0, 2, K_CNT, 0, 0, "kill_sync_cnt");
      kill = 1'b0;
      tick();
      expect_at(0, 0, K_CNT, 0, 1, "post_kill_edge");
      expect_at(0, 0, K_CNT, 1, 0, "post_kill_ch1");

      repeat (4) tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
